// File: rtl/tap_unpacker.sv
// rtl/tap_unpacker.sv - unpacks a packed coefficient word into a ready/valid stream of single taps
module tap_unpacker #(
    parameter int TAPW  = 16,
    parameter int NTAPS = 4,
    localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TAPW*NTAPS-1:0] allTaps,
    input  logic [7:0]            tapnum,
    input  logic                  tapsValid,
    output logic [TAPW-1:0]       coefOut,
    output logic [IDXW-1:0]       coefIdx,
    output logic [7:0]            coefBank,
    output logic                  coefValid,
    input  logic                  coefReady,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TAPW*NTAPS-1:0]   shadow;
    logic [7:0]              bank;
    logic [IDXW-1:0]         idx;
    logic                    over_q;
    logic [TAPW-1:0]         taps [NTAPS];
    logic                    xfer;
    logic                    last;

    for (genvar g = 0; g < NTAPS; g++) begin : g_taps
        assign taps[g] = shadow[TAPW*g +: TAPW];
    end

    assign xfer = (state == S_SEND) && coefReady;
    assign last = (idx == IDXW'(NTAPS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tapsValid) state_nxt = S_SEND;
            S_SEND:  if (xfer && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A strobe outside IDLE never touches the shadow copy; it only flags the loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            bank   <= '0;
            idx    <= '0;
            over_q <= 1'b0;
        end else begin
            if (state == S_IDLE && tapsValid) begin
                shadow <= allTaps;
                bank   <= tapnum;
                idx    <= '0;
                over_q <= 1'b0;
            end else if (tapsValid) begin
                over_q <= 1'b1;
            end
            if (xfer && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        coefValid = (state == S_SEND);
        busy      = (state == S_SEND);
        done      = (state == S_DONE);
        coefOut   = taps[idx];
        coefIdx   = idx;
        coefBank  = bank;
        overrun   = over_q;
    end

endmodule

// File: tb/tb_tap_unpacker.sv
// tb/tb_tap_unpacker.sv - directed bench with a queue-based delivery model for tap_unpacker
module tb_tap_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] allTaps;
    logic [7:0]  tapnum;
    logic        tapsValid;
    logic [15:0] coefOut;
    logic [1:0]  coefIdx;
    logic [7:0]  coefBank;
    logic        coefValid;
    logic        coefReady;
    logic        busy;
    logic        done;
    logic        overrun;

    int passed = 0;
    int total  = 0;

    tap_unpacker #(.TAPW(16), .NTAPS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .allTaps   (allTaps),
        .tapnum    (tapnum),
        .tapsValid (tapsValid),
        .coefOut   (coefOut),
        .coefIdx   (coefIdx),
        .coefBank  (coefBank),
        .coefValid (coefValid),
        .coefReady (coefReady),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got %h want %h", nm, act, exp);
    endtask

    // Expected behaviour: a set is a queue of taps drained one per accepted handshake.
    logic [15:0] mq[$];
    logic        exp_valid, exp_done, exp_over;
    logic [15:0] exp_out;
    logic [7:0]  exp_bank;
    int          exp_idx;
    logic        chk_en = 1'b0;

    logic [15:0] lg_out[$];
    int          lg_idx[$];
    int          done_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("coefValid", coefValid, exp_valid);
            chk("busy",      busy,      exp_valid);
            chk("done",      done,      exp_done);
            chk("overrun",   overrun,   exp_over);
            chk("coefOut",   coefOut,   exp_out);
            chk("coefIdx",   coefIdx,   exp_idx[1:0]);
            chk("coefBank",  coefBank,  exp_bank);
        end
        if (!reset && coefValid && coefReady) begin
            lg_out.push_back(coefOut);
            lg_idx.push_back(int'(coefIdx));
        end
        if (done) done_cnt++;

        if (reset) begin
            mq.delete();
            exp_valid = 0; exp_done = 0; exp_over = 0;
            exp_out = 0; exp_idx = 0; exp_bank = 0;
            chk_en = 1'b1;
        end else if (exp_valid) begin
            if (tapsValid) exp_over = 1;
            if (coefReady) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    exp_valid = 0;
                    exp_done  = 1;
                end else begin
                    exp_idx++;
                    exp_out = mq[0];
                end
            end
        end else if (exp_done) begin
            exp_done = 0;
            if (tapsValid) exp_over = 1;
        end else if (tapsValid) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mq.push_back(16'((allTaps >> (16 * i)) & 64'hFFFF));
            exp_bank  = tapnum;
            exp_over  = 0;
            exp_valid = 1;
            exp_idx   = 0;
            exp_out   = mq[0];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lg_out.delete();
        lg_idx.delete();
        done_cnt = 0;
    endtask

    task automatic check_log(input string nm, input logic [63:0] word);
        chk({nm, "_count"}, lg_out.size(), 4);
        for (int i = 0; i < 4 && i < lg_out.size(); i++) begin
            chk({nm, "_tap"}, lg_out[i], 16'((word >> (16 * i)) & 64'hFFFF));
            chk({nm, "_idx"}, lg_idx[i], i);
        end
    endtask

    task automatic strobe(input logic [63:0] w, input logic [7:0] n);
        allTaps = w;
        tapnum = n;
        tapsValid = 1'b1;
        step();
        tapsValid = 1'b0;
    endtask

    initial begin
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int bound;
        reset = 1'b1; allTaps = '0; tapnum = '0; tapsValid = 1'b0; coefReady = 1'b0;
        done_cnt = 0;
        step(); step();
        reset = 1'b0;
        chk("rst_coefValid", coefValid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);

        // Straight delivery with ready held high.
        clear_log();
        coefReady = 1'b1;
        strobe(64'h0004000500060007, 8'hF4);
        chk("lat_coefValid", coefValid, 1'b1);
        chk("lat_coefBank", coefBank, 8'hF4);
        chk("lit_first_tap", coefOut, 16'h0007);
        repeat (4) step();
        chk("lit_done_after_idx3", done, 1'b1);
        repeat (2) step();
        check_log("stream", 64'h0004000500060007);
        chk("lit_tap3", lg_out.size() > 3 ? lg_out[3] : 16'hxxxx, 16'h0004);
        chk("stream_done_pulses", done_cnt, 1);

        // Ready toggling stalls each tap in place.
        clear_log();
        coefReady = 1'b0;
        strobe(64'h0004000500060007, 8'hF4);
        for (int i = 0; i < 7; i++) begin
            coefReady = pat[i][0];
            step();
        end
        coefReady = 1'b0;
        chk("stall_done", done, 1'b1);
        repeat (3) step();
        check_log("stall", 64'h0004000500060007);
        chk("stall_done_pulses", done_cnt, 1);

        // Strobe during SEND is dropped and flagged.
        clear_log();
        coefReady = 1'b1;
        strobe(64'h0004000500060007, 8'hF4);
        strobe(64'hFFFF000011112222, 8'h5A);
        repeat (6) step();
        check_log("ovr_first", 64'h0004000500060007);
        chk("lit_overrun_set", overrun, 1'b1);
        chk("lit_bank_kept", coefBank, 8'hF4);
        clear_log();
        strobe(64'hFFFF000011112222, 8'h5A);
        chk("lit_overrun_clr", overrun, 1'b0);
        repeat (6) step();
        check_log("ovr_second", 64'hFFFF000011112222);

        // Reset after the idx 1 transfer aborts the set.
        clear_log();
        strobe(64'h123456789ABCDEF, 8'h33);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("lit_abort_valid", coefValid, 1'b0);
        chk("lit_abort_out", coefOut, 16'h0000);
        chk("lit_abort_bank", coefBank, 8'h00);
        chk("abort_transfers", lg_out.size(), 2);
        repeat (2) step();
        chk("abort_no_done", done_cnt, 0);
        clear_log();
        strobe(64'h1234567889ABCDEF, 8'h34);
        repeat (6) step();
        check_log("reload", 64'h1234567889ABCDEF);

        // Load on the cycle right after done.
        strobe(64'h000A000B000C000D, 8'h01);
        bound = 0;
        while (!done && bound < 20) begin
            step();
            bound++;
        end
        chk("done_seen", done, 1'b1);
        step();
        clear_log();
        strobe(64'hA5A55A5A0F0FF0F0, 8'h02);
        chk("lit_b2b_valid", coefValid, 1'b1);
        chk("lit_b2b_idx", coefIdx, 2'd0);
        chk("lit_b2b_overrun", overrun, 1'b0);
        repeat (6) step();
        check_log("b2b", 64'hA5A55A5A0F0FF0F0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
